// File: rtl/modexp_sequencer.sv
// ============================================================================
// Module   : modexp_sequencer
// Purpose  : Sequences a Montgomery-domain left-to-right square-and-multiply
//            modular exponentiation: result = base^exponent mod modulant.
//            Obtains R^2 mod N from an external R-computation unit, then
//            drives a shared external Montgomery multiplier.
// Options  : SKIP_LEADING_ZEROS_EN - start the bit loop at the highest set
//            exponent bit (op count then depends on the exponent value).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module modexp_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int EXP_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] base,
  input  logic [EXP_WIDTH-1:0]  exponent,
  input  logic [DATA_WIDTH-1:0] modulant,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  rc_start,
  input  logic                  rc_done,
  input  logic [DATA_WIDTH-1:0] rc_r_sq,
  output logic                  mm_start,
  output logic [DATA_WIDTH-1:0] mm_a,
  output logic [DATA_WIDTH-1:0] mm_b,
  input  logic                  mm_done,
  input  logic [DATA_WIDTH-1:0] mm_result
);

  localparam int CW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam logic [CW-1:0]         TOP_BIT = CW'(EXP_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] ONE     = DATA_WIDTH'(1);

  typedef enum logic [3:0] {
    S_IDLE, S_RC_KICK, S_RC_WAIT, S_TM_ACC, S_TM_BASE,
    S_SQUARE, S_MULT, S_FROM_MONT, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] base_q, base_d;
  logic [EXP_WIDTH-1:0]  exp_q, exp_d;
  logic [DATA_WIDTH-1:0] r2_q, r2_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] xm_q, xm_d;
  logic [CW-1:0]         bit_q, bit_d;
  logic                  first_q, first_d;   // first cycle of a wait state
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] mm_a_q, mm_a_d;
  logic [DATA_WIDTH-1:0] mm_b_q, mm_b_d;
  logic                  mm_state;
  logic                  mm_take;

`ifdef SKIP_LEADING_ZEROS_EN
  function automatic logic [CW-1:0] msb_index(input logic [EXP_WIDTH-1:0] v);
    msb_index = '0;
    for (int i = 0; i < EXP_WIDTH; i++) begin
      if (v[i]) msb_index = CW'(i);
    end
  endfunction
`endif

  // Next-state, operand and capture logic for the whole sequence
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    exp_d    = exp_q;
    r2_d     = r2_q;
    acc_d    = acc_q;
    xm_d     = xm_q;
    bit_d    = bit_q;
    first_d  = 1'b0;
    result_d = result_q;
    err_d    = err_q;
    mm_a_d   = mm_a_q;
    mm_b_d   = mm_b_q;
    mm_state = (state_q == S_TM_ACC) || (state_q == S_TM_BASE) || (state_q == S_SQUARE) ||
               (state_q == S_MULT)   || (state_q == S_FROM_MONT);
    // a done arriving in the same cycle as our own start pulse cannot belong to it
    mm_take  = mm_state && mm_done && !first_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d = base;
          exp_d  = exponent;
          if (!modulant[0]) begin
            err_d    = 1'b1;
            result_d = '0;
            state_d  = S_DONE;
          end
`ifdef SKIP_LEADING_ZEROS_EN
          else if (exponent == '0) begin
            err_d    = 1'b0;
            result_d = (modulant == ONE) ? '0 : ONE;
            state_d  = S_DONE;
          end
`endif
          else begin
            state_d = S_RC_KICK;
          end
        end
      end
      S_RC_KICK: begin
        state_d = S_RC_WAIT;
        first_d = 1'b1;
      end
      S_RC_WAIT: begin
        // rc_done is a level that may still be high from the previous run
        if (!first_q && rc_done) begin
          r2_d    = rc_r_sq;
          first_d = 1'b1;
`ifdef SKIP_LEADING_ZEROS_EN
          state_d = S_TM_BASE;
          mm_a_d  = base_q;
`else
          state_d = S_TM_ACC;
          mm_a_d  = ONE;
`endif
          mm_b_d  = rc_r_sq;
        end
      end
      S_TM_ACC: begin
        if (mm_take) begin
          acc_d   = mm_result;
          first_d = 1'b1;
          state_d = S_TM_BASE;
          mm_a_d  = base_q;
          mm_b_d  = r2_q;
        end
      end
      S_TM_BASE: begin
        if (mm_take) begin
          xm_d    = mm_result;
          first_d = 1'b1;
`ifdef SKIP_LEADING_ZEROS_EN
          // top set bit is consumed by starting with acc = xm
          acc_d = mm_result;
          if (msb_index(exp_q) == '0) begin
            state_d = S_FROM_MONT;
            mm_a_d  = mm_result;
            mm_b_d  = ONE;
          end else begin
            bit_d   = msb_index(exp_q) - CW'(1);
            state_d = S_SQUARE;
            mm_a_d  = mm_result;
            mm_b_d  = mm_result;
          end
`else
          bit_d   = TOP_BIT;
          state_d = S_SQUARE;
          mm_a_d  = acc_q;
          mm_b_d  = acc_q;
`endif
        end
      end
      S_SQUARE, S_MULT: begin
        if (mm_take) begin
          acc_d   = mm_result;
          first_d = 1'b1;
          if ((state_q == S_SQUARE) && exp_q[bit_q]) begin
            state_d = S_MULT;
            mm_a_d  = mm_result;
            mm_b_d  = xm_q;
          end else if (bit_q == '0) begin
            state_d = S_FROM_MONT;
            mm_a_d  = mm_result;
            mm_b_d  = ONE;
          end else begin
            bit_d   = bit_q - CW'(1);
            state_d = S_SQUARE;
            mm_a_d  = mm_result;
            mm_b_d  = mm_result;
          end
        end
      end
      S_FROM_MONT: begin
        if (mm_take) begin
          result_d = mm_result;
          err_d    = 1'b0;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      exp_q    <= '0;
      r2_q     <= '0;
      acc_q    <= '0;
      xm_q     <= '0;
      bit_q    <= '0;
      first_q  <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
      mm_a_q   <= '0;
      mm_b_q   <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      exp_q    <= exp_d;
      r2_q     <= r2_d;
      acc_q    <= acc_d;
      xm_q     <= xm_d;
      bit_q    <= bit_d;
      first_q  <= first_d;
      result_q <= result_d;
      err_q    <= err_d;
      mm_a_q   <= mm_a_d;
      mm_b_q   <= mm_b_d;
    end
  end

  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done     = (state_q == S_DONE);
  assign err      = err_q;
  assign result   = result_q;
  assign rc_start = (state_q == S_RC_KICK);
  assign mm_start = first_q && mm_state;
  assign mm_a     = mm_a_q;
  assign mm_b     = mm_b_q;

endmodule

`default_nettype wire

// File: tb/tb_modexp_sequencer.sv
// ============================================================================
// Module   : tb_modexp_sequencer
// Purpose  : Self-checking bench for modexp_sequencer with behavioural
//            R-computation and Montgomery-multiplier responders.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_modexp_sequencer;

  localparam int DW = 8;
  localparam int EW = 8;
`ifdef SKIP_LEADING_ZEROS_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] base;
  logic [EW-1:0] exponent;
  logic [DW-1:0] modulant;
  logic          busy, done, err;
  logic [DW-1:0] result;
  logic          rc_start;
  logic          rc_done;
  logic [DW-1:0] rc_r_sq;
  logic          mm_start;
  logic [DW-1:0] mm_a, mm_b;
  logic          mm_done;
  logic [DW-1:0] mm_result;

  int checks   = 0;
  int failures = 0;
  int mm_cnt   = 0;
  int rc_cnt   = 0;
  int done_cnt = 0;
  int cur_n    = 1;
  int poison_req = 0;
  int poison_ack = 0;

  always #5 clk = ~clk;

  modexp_sequencer #(.DATA_WIDTH(DW), .EXP_WIDTH(EW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base(base), .exponent(exponent),
    .modulant(modulant), .busy(busy), .done(done), .err(err), .result(result),
    .rc_start(rc_start), .rc_done(rc_done), .rc_r_sq(rc_r_sq),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_done(mm_done),
    .mm_result(mm_result)
  );

  // ---------------- reference arithmetic ----------------
  function automatic int modpow(int b, int e, int n);
    int r = 1;
    if (n == 1) return 0;
    for (int k = 0; k < e; k++) r = (r * b) % n;
    return r % n;
  endfunction

  function automatic int mont(int a, int b, int n);
    int rinv = 0;
    if (n <= 1) return 0;
    for (int x = 1; x < n; x++) if (((1 << DW) * x) % n == 1) rinv = x;
    return (((a * b) % n) * rinv) % n;
  endfunction

  function automatic int popcnt(int v);
    int c = 0;
    for (int k = 0; k < EW; k++) if (v[k]) c++;
    return c;
  endfunction

  function automatic int exp_mm_ops(int e);
    int j = 0;
    if (!SKIP) return 3 + EW + popcnt(e);
    if (e == 0) return 0;
    for (int k = 0; k < EW; k++) if (e[k]) j = k;
    return 2 + j + popcnt(e) - 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Responders for the R-computation unit and Montgomery multiplier, plus event counters
  initial begin : responders
    int mm_phase = 0, mm_del = 0, rc_phase = 0, rc_del = 0;
    mm_done = 1'b0; mm_result = '0; rc_done = 1'b0; rc_r_sq = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        mm_phase = 0; rc_phase = 0; mm_done = 1'b0;
        continue;
      end
      if (done) done_cnt++;
      if (mm_start) mm_cnt++;
      if (rc_start) rc_cnt++;
      if (poison_req != poison_ack) begin
        rc_done = 1'b1; rc_r_sq = '0; poison_ack = poison_req;
      end
      mm_done = 1'b0;
      mm_result = DW'($urandom);
      if (mm_phase == 0) begin
        if (mm_start) begin mm_phase = 1; mm_del = $urandom_range(0, 3); end
      end else if (mm_del == 0) begin
        mm_done = 1'b1; mm_result = DW'(mont(int'(mm_a), int'(mm_b), cur_n)); mm_phase = 0;
      end else mm_del--;
      case (rc_phase)
        0: if (rc_start) rc_phase = 1;
        1: begin rc_phase = 2; rc_del = $urandom_range(0, 3); end  // leave old level visible
        default: begin
          if (rc_del == 0) begin
            rc_done = 1'b1; rc_r_sq = DW'((1 << (2 * DW)) % cur_n); rc_phase = 0;
          end else begin
            rc_done = 1'b0; rc_del--;
          end
        end
      endcase
    end
  end

  task automatic run_op(input string tag, input int n, input int b, input int e, input bit poke);
    int cyc = 0;
    int d0 = done_cnt, m0 = mm_cnt, r0 = rc_cnt;
    bit even = (n % 2 == 0);
    bit fast = even || (SKIP && e == 0);
    int exp_res = even ? 0 : modpow(b, e, n);
    cur_n = (n == 0) ? 1 : n;
    base = DW'(b); exponent = EW'(e); modulant = DW'(n); start = 1'b1;
    tick();
    start = 1'b0;
    base = DW'($urandom); exponent = EW'($urandom); modulant = DW'($urandom);
    if (fast) check({tag, "_fast_done"}, done, 1'b1);
    else      check({tag, "_busy"}, busy, 1'b1);
    while (done !== 1'b1 && cyc < 3000) begin
      if (poke && cyc == 5) begin
        start = 1'b1; modulant = 8'd7; base = 8'd3; exponent = 8'd6;
      end
      tick();
      start = 1'b0;
      cyc++;
    end
    check({tag, "_no_timeout"}, (cyc < 3000), 1'b1);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_err"}, err, even);
    check({tag, "_busy_at_done"}, busy, 1'b0);
    check({tag, "_mm_ops"}, mm_cnt - m0, even ? 0 : exp_mm_ops(e));
    check({tag, "_rc_ops"}, rc_cnt - r0, fast ? 0 : 1);
    tick();
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_result_held"}, result, exp_res);
    tick(); tick();
    check({tag, "_single_done"}, done_cnt - d0, 1);
  endtask

  initial begin : main
    int cyc;
    int d0, m0;
    rst_n = 1'b0; start = 1'b0; base = '0; exponent = '0; modulant = '0;
    tick(); tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_result", result, 0);
    check("rst_rc_start", rc_start, 1'b0);
    check("rst_mm_start", mm_start, 1'b0);
    check("rst_mm_a", mm_a, 0);
    check("rst_mm_b", mm_b, 0);
    rst_n = 1'b1;
    tick();

    run_op("n11_b4_e13", 11, 4, 13, 1'b0);
    run_op("n10_even", 10, 3, 5, 1'b0);
    run_op("n13_b5_e0", 13, 5, 0, 1'b0);
    run_op("n1_b0_e5", 1, 0, 5, 1'b0);
    run_op("n0_even", 0, 0, 7, 1'b0);

    // stale rc_done level with a bogus R^2 present when rc_start pulses
    poison_req++;
    tick(); tick();
    run_op("stale_rc", 11, 4, 13, 1'b0);

    run_op("start_while_busy", 11, 4, 13, 1'b1);

    // reset while the first MULT is in progress
    d0 = done_cnt; m0 = mm_cnt; cyc = 0;
    cur_n = 11; base = 8'd4; exponent = 8'd13; modulant = 8'd11; start = 1'b1;
    tick();
    start = 1'b0;
    while ((mm_cnt - m0) < (SKIP ? 3 : 8) && cyc < 3000) begin tick(); cyc++; end
    check("mid_rst_reached_mult", (cyc < 3000), 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_mm_start", mm_start, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_result", result, 0);
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    check("mid_rst_no_done", done_cnt - d0, 0);
    run_op("after_rst_n7_b3_e6", 7, 3, 6, 1'b0);

    for (int t = 0; t < 24; t++) begin
      int n = $urandom_range(0, 255);
      int b;
      if ($urandom_range(0, 4) != 0) n = n | 1;
      b = (n == 0) ? 0 : $urandom_range(0, n - 1);
      run_op($sformatf("rand%0d", t), n, b, $urandom_range(0, 255), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
